// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = BYTE_W * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus, valid/yumi request with a separate read response.
interface mem_stage_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    dmem_v_o;
  logic                    dmem_wen_o;
  logic [ADDR_WIDTH-1:0]   dmem_addr_o;
  logic [DATA_WIDTH-1:0]   dmem_wdata_o;
  logic [DATA_WIDTH/8-1:0] dmem_byte_en_o;
  logic                    dmem_yumi_i;
  logic                    dmem_v_i;
  logic [DATA_WIDTH-1:0]   dmem_data_i;

  modport master (
    output dmem_v_o, dmem_wen_o, dmem_addr_o, dmem_wdata_o, dmem_byte_en_o,
    input  dmem_yumi_i, dmem_v_i, dmem_data_i
  );

  modport slave (
    input  dmem_v_o, dmem_wen_o, dmem_addr_o, dmem_wdata_o, dmem_byte_en_o,
    output dmem_yumi_i, dmem_v_i, dmem_data_i
  );
endinterface

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Store byte-lane steering and LBU byte extraction, little-endian lanes.
module mem_byte_lane
  import mem_stage_ctrl_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic              is_store,
  input  logic              is_byte,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] load_word,
  output logic [WORD_W-1:0] wdata,
  output logic [LANES-1:0]  byte_en,
  output logic [WORD_W-1:0] load_data
);

  always_comb begin
    wdata     = store_data;
    byte_en   = '0;
    load_data = load_word;
    if (is_byte) begin
      wdata     = {LANES{store_data[BYTE_W-1:0]}};
      load_data = {{(WORD_W-BYTE_W){1'b0}}, load_word[BYTE_W*addr_lo +: BYTE_W]};
    end
    if (is_store) begin
      byte_en = is_byte ? (LANES'(1) << addr_lo) : '1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: single-outstanding dmem access, pipeline stall and load writeback.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_op_v_i,
  input  logic                  is_store_i,
  input  logic                  is_byte_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  wb_v_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  mem_stage_ctrl_if.master      dmem
);

  mem_state_e            state, state_n;
  logic                  is_store_q, is_byte_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] store_data_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [DATA_WIDTH-1:0] lane_wdata, lane_load;
  logic [LANES-1:0]      lane_byte_en;
  logic                  aligned, accept, in_req;

  assign aligned = is_byte_i | (addr_i[1:0] == 2'b00);
  assign accept  = (state == IDLE) & mem_op_v_i & aligned;
  assign in_req  = (state == REQ);

  mem_byte_lane u_lane (
    .addr_lo    (addr_q[1:0]),
    .is_store   (is_store_q),
    .is_byte    (is_byte_q),
    .store_data (store_data_q),
    .load_word  (dmem.dmem_data_i),
    .wdata      (lane_wdata),
    .byte_en    (lane_byte_en),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      is_store_q   <= 1'b0;
      is_byte_q    <= 1'b0;
      addr_q       <= '0;
      store_data_q <= '0;
      wb_data_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        is_store_q   <= is_store_i;
        is_byte_q    <= is_byte_i;
        addr_q       <= addr_i;
        store_data_q <= store_data_i;
      end
      if ((state == RESP) && dmem.dmem_v_i) begin
        wb_data_q <= lane_load;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = REQ;
      REQ:     if (dmem.dmem_yumi_i) state_n = is_store_q ? DONE : RESP;
      RESP:    if (dmem.dmem_v_i) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request fields are forced to zero outside REQ so the bus is quiet between accesses.
  always_comb begin
    stall_o             = accept | (state == REQ) | (state == RESP);
    misaligned_o        = (state == IDLE) & mem_op_v_i & ~aligned;
    wb_v_o              = (state == DONE) & ~is_store_q;
    wb_data_o           = wb_data_q;
    dmem.dmem_v_o       = in_req;
    dmem.dmem_wen_o     = in_req & is_store_q;
    dmem.dmem_addr_o    = '0;
    dmem.dmem_wdata_o   = '0;
    dmem.dmem_byte_en_o = '0;
    if (in_req) begin
      dmem.dmem_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      dmem.dmem_wdata_o   = is_store_q ? lane_wdata : '0;
      dmem.dmem_byte_en_o = lane_byte_en;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_op_v_i, is_store_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic        stall_o, misaligned_o, wb_v_o;
  logic [31:0] wb_data_o;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_stage_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

  mem_stage_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_op_v_i   (mem_op_v_i),
    .is_store_i   (is_store_i),
    .is_byte_i    (is_byte_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .wb_v_o       (wb_v_o),
    .wb_data_o    (wb_data_o),
    .dmem         (dmem_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_bus_quiet(input string tag);
    check_eq({tag, ".dmem_v"},    {31'b0, dmem_bus.dmem_v_o},   32'h0);
    check_eq({tag, ".wen"},       {31'b0, dmem_bus.dmem_wen_o}, 32'h0);
    check_eq({tag, ".addr"},      dmem_bus.dmem_addr_o,         32'h0);
    check_eq({tag, ".wdata"},     dmem_bus.dmem_wdata_o,        32'h0);
    check_eq({tag, ".byte_en"},   {28'b0, dmem_bus.dmem_byte_en_o}, 32'h0);
  endtask

  task automatic set_op(input logic v, input logic st, input logic by,
                        input logic [31:0] a, input logic [31:0] d);
    mem_op_v_i = v; is_store_i = st; is_byte_i = by; addr_i = a; store_data_i = d;
  endtask

  initial begin
    reset = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    dmem_bus.dmem_yumi_i = 1'b0;
    dmem_bus.dmem_v_i    = 1'b0;
    dmem_bus.dmem_data_i = 32'h0;
    repeat (2) @(posedge clk);
    next_cycle(); settle();
    check_eq("rst.stall", {31'b0, stall_o}, 32'h0);
    check_eq("rst.wb_v", {31'b0, wb_v_o}, 32'h0);
    check_eq("rst.wb_data", wb_data_o, 32'h0);
    check_eq("rst.misal", {31'b0, misaligned_o}, 32'h0);
    check_bus_quiet("rst");
    reset = 1'b0;

    // SW 0x100
    next_cycle(); set_op(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF); settle();
    check_eq("sw.idle.stall", {31'b0, stall_o}, 32'h1);
    check_eq("sw.idle.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h0);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b1; settle();
    check_eq("sw.req.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h1);
    check_eq("sw.req.wen", {31'b0, dmem_bus.dmem_wen_o}, 32'h1);
    check_eq("sw.req.addr", dmem_bus.dmem_addr_o, 32'h100);
    check_eq("sw.req.wdata", dmem_bus.dmem_wdata_o, 32'hDEADBEEF);
    check_eq("sw.req.byte_en", {28'b0, dmem_bus.dmem_byte_en_o}, 32'hF);
    check_eq("sw.req.stall", {31'b0, stall_o}, 32'h1);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b0; settle();
    check_eq("sw.done.stall", {31'b0, stall_o}, 32'h0);
    check_eq("sw.done.wb_v", {31'b0, wb_v_o}, 32'h0);
    check_bus_quiet("sw.done");

    // SB 0x203 issued straight after DONE (back-to-back acceptance)
    next_cycle(); set_op(1'b1, 1'b1, 1'b1, 32'h203, 32'h000000A5); settle();
    check_eq("sb.idle.stall", {31'b0, stall_o}, 32'h1);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b1; settle();
    check_eq("sb.req.addr", dmem_bus.dmem_addr_o, 32'h200);
    check_eq("sb.req.wdata", dmem_bus.dmem_wdata_o, 32'hA5A5A5A5);
    check_eq("sb.req.byte_en", {28'b0, dmem_bus.dmem_byte_en_o}, 32'h8);
    check_eq("sb.req.wen", {31'b0, dmem_bus.dmem_wen_o}, 32'h1);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b0; settle();
    check_eq("sb.done.stall", {31'b0, stall_o}, 32'h0);
    check_eq("sb.done.wb_v", {31'b0, wb_v_o}, 32'h0);

    // LBU 0x302
    next_cycle(); set_op(1'b1, 1'b0, 1'b1, 32'h302, 32'h0); settle();
    check_eq("lbu.idle.stall", {31'b0, stall_o}, 32'h1);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b1; settle();
    check_eq("lbu.req.addr", dmem_bus.dmem_addr_o, 32'h300);
    check_eq("lbu.req.wen", {31'b0, dmem_bus.dmem_wen_o}, 32'h0);
    check_eq("lbu.req.byte_en", {28'b0, dmem_bus.dmem_byte_en_o}, 32'h0);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b0;
    dmem_bus.dmem_v_i = 1'b1; dmem_bus.dmem_data_i = 32'h11223344; settle();
    check_eq("lbu.resp.stall", {31'b0, stall_o}, 32'h1);
    check_eq("lbu.resp.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h0);
    check_eq("lbu.resp.wb_v", {31'b0, wb_v_o}, 32'h0);
    next_cycle(); dmem_bus.dmem_v_i = 1'b0; dmem_bus.dmem_data_i = 32'h0; settle();
    check_eq("lbu.done.wb_v", {31'b0, wb_v_o}, 32'h1);
    check_eq("lbu.done.wb_data", wb_data_o, 32'h00000022);
    check_eq("lbu.done.stall", {31'b0, stall_o}, 32'h0);
    next_cycle(); set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
    check_eq("lbu.after.wb_v", {31'b0, wb_v_o}, 32'h0);
    check_eq("lbu.after.wb_data", wb_data_o, 32'h00000022);

    // LW 0x400, yumi withheld 3 cycles, response after 2 empty RESP cycles
    next_cycle(); set_op(1'b1, 1'b0, 1'b0, 32'h400, 32'h0); settle();
    check_eq("lw.idle.stall", {31'b0, stall_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); settle();
      check_eq("lw.wait.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h1);
      check_eq("lw.wait.addr", dmem_bus.dmem_addr_o, 32'h400);
      check_eq("lw.wait.stall", {31'b0, stall_o}, 32'h1);
    end
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b1; settle();
    check_eq("lw.yumi.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h1);
    check_eq("lw.yumi.addr", dmem_bus.dmem_addr_o, 32'h400);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); dmem_bus.dmem_yumi_i = 1'b0; settle();
      check_eq("lw.resp_wait.stall", {31'b0, stall_o}, 32'h1);
      check_eq("lw.resp_wait.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h0);
    end
    next_cycle(); dmem_bus.dmem_v_i = 1'b1; dmem_bus.dmem_data_i = 32'hCAFEF00D; settle();
    check_eq("lw.resp.stall", {31'b0, stall_o}, 32'h1);
    next_cycle(); dmem_bus.dmem_v_i = 1'b0; dmem_bus.dmem_data_i = 32'h0; settle();
    check_eq("lw.done.wb_v", {31'b0, wb_v_o}, 32'h1);
    check_eq("lw.done.wb_data", wb_data_o, 32'hCAFEF00D);
    check_eq("lw.done.stall", {31'b0, stall_o}, 32'h0);

    // LW 0x401 misaligned
    next_cycle(); set_op(1'b1, 1'b0, 1'b0, 32'h401, 32'h0); settle();
    check_eq("mis.pulse", {31'b0, misaligned_o}, 32'h1);
    check_eq("mis.stall", {31'b0, stall_o}, 32'h0);
    check_eq("mis.dmem_v", {31'b0, dmem_bus.dmem_v_o}, 32'h0);
    next_cycle(); set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
    check_eq("mis.clear", {31'b0, misaligned_o}, 32'h0);
    check_eq("mis.after.stall", {31'b0, stall_o}, 32'h0);
    check_bus_quiet("mis.after");

    // Reset in RESP, then a late response
    next_cycle(); set_op(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b1;
    next_cycle(); dmem_bus.dmem_yumi_i = 1'b0; reset = 1'b1; settle();
    check_eq("rstresp.stall_pre", {31'b0, stall_o}, 32'h1);
    next_cycle(); reset = 1'b0; set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    dmem_bus.dmem_v_i = 1'b1; dmem_bus.dmem_data_i = 32'h12345678; settle();
    check_eq("rstresp.stall", {31'b0, stall_o}, 32'h0);
    check_eq("rstresp.wb_v", {31'b0, wb_v_o}, 32'h0);
    check_eq("rstresp.wb_data", wb_data_o, 32'h0);
    check_bus_quiet("rstresp");
    next_cycle(); dmem_bus.dmem_v_i = 1'b0; dmem_bus.dmem_data_i = 32'h0; settle();
    check_eq("rstresp.late.wb_v", {31'b0, wb_v_o}, 32'h0);
    check_eq("rstresp.late.wb_data", wb_data_o, 32'h0);
    check_eq("rstresp.late.stall", {31'b0, stall_o}, 32'h0);
    check_bus_quiet("rstresp.late");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the core pipeline, directly downstream of the instruction decode controller. It consumes the decoded memory-op qualifiers (valid memory op, store vs. load, byte vs. word), drives a single-outstanding data-memory request over a valid/yumi handshake, and performs store byte-lane steering and LBU byte extraction. It stalls the pipeline until the access completes and returns load data for register-file writeback.

## Interface
- ADDR_WIDTH, 32, byte address width; low 2 bits select the byte lane.
- DATA_WIDTH, 32, fixed word width; 4 byte lanes.

- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- mem_op_v_i  in  1  instruction in MEM stage is a memory op (decode is_mem_op)
- is_store_i  in  1  1 = SW/SB, 0 = LW/LBU
- is_byte_i  in  1  1 = SB/LBU, 0 = SW/LW
- addr_i  in  32  effective byte address
- store_data_i  in  32  rt value for stores
- stall_o  out  1  hold all upstream stages
- misaligned_o  out  1  one-cycle pulse: word op with addr_i[1:0] != 0
- wb_v_o  out  1  one-cycle pulse: load result valid
- wb_data_o  out  32  load result, zero-extended for LBU
- dmem_v_o  out  1  request valid
- dmem_wen_o  out  1  request is a write
- dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata_o  out  32  write data, lane-steered
- dmem_byte_en_o  out  4  write byte enables
- dmem_yumi_i  in  1  memory accepts request this cycle
- dmem_v_i  in  1  read response valid
- dmem_data_i  in  32  read response word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: if mem_op_v_i and aligned -> latch is_store, is_byte, addr, store_data -> REQ. If mem_op_v_i and word op with addr_i[1:0] != 0 -> misaligned_o=1 this cycle, no request, stay IDLE.
- REQ: dmem_v_o=1 with latched fields held stable. On dmem_yumi_i: store -> DONE, load -> RESP. Without yumi: stay REQ indefinitely.
- RESP: wait for dmem_v_i; capture wb_data -> DONE. dmem_v_i is ignored in all other states.
- DONE: stall_o=0; wb_v_o=1 if latched op is a load; -> IDLE unconditionally. mem_op_v_i in DONE belongs to the completing instruction and is ignored.
- stall_o = (IDLE & mem_op_v_i & aligned) | REQ | RESP.
- Store word: wdata = store_data, byte_en = 4'hF. Store byte: wdata = {4{store_data[7:0]}}, byte_en = 4'b0001 << addr[1:0].
- Load word: wb_data = dmem_data_i. LBU: wb_data = {24'b0, dmem_data_i[8*addr[1:0] +: 8]} (little-endian lanes).
- Loads: dmem_wen_o=0, byte_en=4'h0.

## Timing
- Reset: state=IDLE; all outputs 0, including wb_data_o and dmem_byte_en_o.
- Reset mid-operation: abandon op next edge; a late dmem_v_i is ignored in IDLE.
- Store with immediate yumi: IDLE(accept) -> REQ(yumi) -> DONE; 2 stall cycles.
- Load with immediate yumi and response the next cycle: IDLE -> REQ -> RESP -> DONE; wb_v_o in cycle 3 after acceptance; 3 stall cycles.
- Memory must not assert dmem_v_i in the yumi cycle; response arrives at earliest one cycle later.
- wb_data_o held from DONE until the next capture; dmem_* outputs are 0 outside REQ.
- Back-to-back memory ops: next op accepted in the IDLE cycle following DONE.

## Structure
- Shared package: mem_state_e enum (IDLE, REQ, RESP, DONE) and byte-lane width constants.
- Sub-module mem_byte_lane: combinational store steering (wdata, byte_en) and load extraction from addr[1:0], is_byte.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, yumi immediate -> dmem_addr 0x100, byte_en 4'hF, wen=1, stall 2 cycles, no wb_v_o.
- SB addr 0x203, data 0x000000A5 -> wdata 0xA5A5A5A5, byte_en 4'b1000.
- LBU addr 0x302, response 0x11223344 -> wb_v_o pulse, wb_data 0x00000022.
- LW addr 0x400, yumi withheld 3 cycles, response 2 cycles later 0xCAFEF00D -> dmem_v_o held stable, stall_o held throughout, wb_data 0xCAFEF00D.
- LW addr 0x401 -> misaligned_o one pulse, dmem_v_o never asserted, stall_o 0.
- Reset asserted in RESP, then dmem_v_i -> state IDLE, wb_v_o stays 0, all outputs 0.
